// File: rtl/adder_share_pkg.sv
// Shared constants and FSM encoding for the shared-adder arbiter.
package adder_share_pkg;
    localparam int ADD_W     = 32;
    localparam int SUM_W     = 33;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, cyclically.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr_i) + 32'(i)) % NUM_REQ);
            if (!found && en_i && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end
endmodule

// File: rtl/adder32_share_arbiter.sv
// Shares one external 33-bit-result adder among NUM_REQ requesters, one op at a time.
// Optional exact-sum checker enabled by defining EXACT_CHECK_EN (adds err_o/err_cnt_o).
module adder32_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*ADD_W-1:0] req_add1_i,
    input  logic [NUM_REQ*ADD_W-1:0] req_add2_i,
    output logic [ADD_W-1:0]         add1_o,
    output logic [ADD_W-1:0]         add2_o,
    input  logic [SUM_W-1:0]         sum_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [SUM_W-1:0]         rsp_result_o,
    output logic                     busy_o
`ifdef EXACT_CHECK_EN
    ,
    output logic                     err_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
`endif
);
    state_e                          state_q;
    logic [ID_W-1:0]                 ptr_q, id_q;
    logic [ADD_W-1:0]                add1_q, add2_q;
    logic [SUM_W-1:0]                result_q;
    logic                            rsp_valid_q, busy_q;
    logic [NUM_REQ-1:0][ADD_W-1:0]   add1_v, add2_v;
    logic [NUM_REQ-1:0]              gnt;
    logic [ID_W-1:0]                 gnt_idx, ptr_d;
    logic                            arb_en;

    assign add1_v = req_add1_i;
    assign add2_v = req_add2_i;

    // Gating with rst_ni keeps every output low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_ni;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef EXACT_CHECK_EN
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [SUM_W-1:0]     exact;
    assign exact = {1'b0, add1_q} + {1'b0, add2_q};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            add1_q      <= '0;
            add2_q      <= '0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef EXACT_CHECK_EN
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        add1_q  <= add1_v[gnt_idx];
                        add2_q  <= add2_v[gnt_idx];
                        id_q    <= gnt_idx;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    result_q    <= sum_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`ifdef EXACT_CHECK_EN
                    err_q <= (sum_i != exact);
                    if ((sum_i != exact) && (err_cnt_q != '1))
                        err_cnt_q <= err_cnt_q + 1'b1;
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifdef EXACT_CHECK_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = gnt;
    assign add1_o       = add1_q;
    assign add2_o       = add2_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign busy_o       = busy_q;
`ifdef EXACT_CHECK_EN
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;
`endif
endmodule

// File: tb/tb_adder32_share_arbiter.sv
// Scoreboard bench for adder32_share_arbiter; sum_i comes from an exact adder model with optional bit-0 flip.
module tb_adder32_share_arbiter;
    localparam int NUM_REQ = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*32-1:0]   req_add1_i, req_add2_i;
    logic [31:0]             add1_o, add2_o;
    logic [32:0]             sum_i;
    logic                    rsp_valid_o, rsp_ready_i;
    logic [1:0]              rsp_id_o;
    logic [32:0]             rsp_result_o;
    logic                    busy_o;
    logic                    flip;
`ifdef EXACT_CHECK_EN
    logic                    err_o;
    logic [15:0]             err_cnt_o;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [32:0] res;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign sum_i = ({1'b0, add1_o} + {1'b0, add2_o}) ^ {32'd0, flip};

    adder32_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_add1_i   (req_add1_i),
        .req_add2_i   (req_add2_i),
        .add1_o       (add1_o),
        .add2_o       (add2_o),
        .sum_i        (sum_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .busy_o       (busy_o)
`ifdef EXACT_CHECK_EN
        ,
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
`endif
    );

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_add1_i[id*32 +: 32] = a;
        req_add2_i[id*32 +: 32] = b;
    endtask

    task automatic push_exp(input int id, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        x.id  = 2'(id);
        x.res = {1'b0, a} + {1'b0, b};
        sb.push_back(x);
    endtask

    // Returns at the negedge where some requester is granted.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (|req_ready_o) ok = 1'b1;
        end
    endtask

    // Returns at the negedge where a response handshake happens.
    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = 1'b1; flip = 1'b0;
        req_add1_i = '0; req_add2_i = '0;
        @(negedge clk_i);
        tests++;
        if ({busy_o, rsp_valid_o, add1_o, add2_o, rsp_result_o, rsp_id_o, req_ready_o} !== '0) begin
            fails++; $display("FAIL reset_outputs busy=%b vld=%b a1=%h a2=%h res=%h", busy_o, rsp_valid_o, add1_o, add2_o, rsp_result_o);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        // Start an op and kill it mid-ISSUE.
        set_req(0, 32'h0000_0005, 32'h0000_0006);
        req_valid_i = 4'b0001;
        wait_grant(ok);
        @(posedge clk_i); #1;
        req_valid_i = '0; rst_ni = 1'b0;
        #1;
        tests++;
        if ({busy_o, rsp_valid_o, add1_o, add2_o, rsp_result_o, rsp_id_o, req_ready_o} !== '0) begin
            fails++; $display("FAIL reset_mid_issue busy=%b vld=%b a1=%h a2=%h res=%h", busy_o, rsp_valid_o, add1_o, add2_o, rsp_result_o);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_no_rsp busy=%b vld=%b need 0 0", busy_o, rsp_valid_o);
        end
        // Pointer back at 0: with req0 and req1 pending, req0 wins.
        @(posedge clk_i); #1;
        set_req(1, 32'h0000_0100, 32'h0000_0200);
        push_exp(0, 32'h0000_0005, 32'h0000_0006);
        req_valid_i = 4'b0011;
        @(negedge clk_i);
        tests++;
        if (req_ready_o !== 4'b0001) begin
            fails++; $display("FAIL reset_ptr ready=%b need 0001", req_ready_o);
        end
        @(posedge clk_i); #1 req_valid_i = '0;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_id_o !== e.id || rsp_result_o !== e.res) begin
            fails++; $display("FAIL reset_op ok=%0d id=%0d res=%h need id=%0d res=%h", ok, rsp_id_o, rsp_result_o, e.id, e.res);
        end
    endtask

    task automatic test_single_op();
        @(posedge clk_i); #1;
        set_req(0, 32'h29AF_2430, 32'h7A1B_9ABC);
        push_exp(0, 32'h29AF_2430, 32'h7A1B_9ABC);
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        tests++;
        if (req_ready_o !== 4'b0001 || busy_o !== 1'b0) begin
            fails++; $display("FAIL single_grant ready=%b busy=%b need 0001 0", req_ready_o, busy_o);
        end
        @(posedge clk_i); #1 req_valid_i = '0;
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0 || add1_o !== 32'h29AF_2430 || add2_o !== 32'h7A1B_9ABC || req_ready_o !== '0) begin
            fails++; $display("FAIL single_issue busy=%b vld=%b a1=%h a2=%h", busy_o, rsp_valid_o, add1_o, add2_o);
        end
        @(negedge clk_i);
        e = sb.pop_front();
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== e.id || rsp_result_o !== 33'h0_A3CA_BEEC || rsp_result_o !== e.res) begin
            fails++; $display("FAIL single_rsp vld=%b id=%0d res=%h need 1 0 %h", rsp_valid_o, rsp_id_o, rsp_result_o, e.res);
        end
        @(negedge clk_i);
        tests++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || add1_o !== 32'h29AF_2430) begin
            fails++; $display("FAIL single_idle vld=%b busy=%b a1=%h", rsp_valid_o, busy_o, add1_o);
        end
    endtask

    task automatic test_carry();
        bit ok;
        @(posedge clk_i); #1;
        set_req(3, 32'hFFFF_FFFF, 32'h0000_0001);
        push_exp(3, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid_i = 4'b1000;
        wait_grant(ok);
        @(posedge clk_i); #1 req_valid_i = '0;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_id_o !== 2'd3 || rsp_result_o !== 33'h1_0000_0000 || rsp_result_o !== e.res) begin
            fails++; $display("FAIL carry ok=%0d id=%0d res=%h need 3 100000000", ok, rsp_id_o, rsp_result_o);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int last;
        last = 0;
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) set_req(k, 32'h1111_1111 * (k + 1), 32'h0F0F_0F0F + k);
        for (int j = 0; j < 5; j++) push_exp(j % 4, 32'h1111_1111 * (j % 4 + 1), 32'h0F0F_0F0F + (j % 4));
        req_valid_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(ok);
            tests++;
            if (!ok || req_ready_o !== 4'(1 << (j % 4))) begin
                fails++; $display("FAIL fair_grant%0d ready=%b need %b", j, req_ready_o, 4'(1 << (j % 4)));
            end
            if (j > 0) begin
                tests++;
                if (cyc - last !== 3) begin
                    fails++; $display("FAIL fair_spacing%0d gap=%0d need 3", j, cyc - last);
                end
            end
            last = cyc;
            if (j == 4) begin
                @(posedge clk_i); #1 req_valid_i = '0;
            end
            wait_hs(ok);
            e = sb.pop_front();
            tests++;
            if (!ok || rsp_id_o !== e.id || rsp_result_o !== e.res) begin
                fails++; $display("FAIL fair_rsp%0d id=%0d res=%h need %0d %h", j, rsp_id_o, rsp_result_o, e.id, e.res);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        set_req(1, 32'h8000_0001, 32'h8000_0002);
        push_exp(1, 32'h8000_0001, 32'h8000_0002);
        req_valid_i = 4'b0010;
        wait_grant(ok);
        @(posedge clk_i); #1;
        req_valid_i = '0;
        set_req(0, 32'h0000_0ABC, 32'h0000_0DEF);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) ok = 1'b1;
        end
        #1 req_valid_i = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_i);
            tests++;
            if (!ok || rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_result_o !== 33'h1_0000_0003 || req_ready_o !== '0 || busy_o !== 1'b1) begin
                fails++; $display("FAIL bp_hold%0d vld=%b id=%0d res=%h ready=%b busy=%b", k, rsp_valid_o, rsp_id_o, rsp_result_o, req_ready_o, busy_o);
            end
        end
        push_exp(0, 32'h0000_0ABC, 32'h0000_0DEF);
        @(posedge clk_i); #1 rsp_ready_i = 1'b1;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_id_o !== e.id || rsp_result_o !== e.res) begin
            fails++; $display("FAIL bp_rsp id=%0d res=%h need %0d %h", rsp_id_o, rsp_result_o, e.id, e.res);
        end
        wait_grant(ok);
        tests++;
        if (!ok || req_ready_o !== 4'b0001) begin
            fails++; $display("FAIL bp_next_grant ready=%b need 0001", req_ready_o);
        end
        @(posedge clk_i); #1 req_valid_i = '0;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_id_o !== e.id || rsp_result_o !== e.res) begin
            fails++; $display("FAIL bp_next_rsp id=%0d res=%h need %0d %h", rsp_id_o, rsp_result_o, e.id, e.res);
        end
    endtask

`ifdef EXACT_CHECK_EN
    task automatic test_exact_check();
        bit ok;
        exp_t x;
        @(posedge clk_i); #1;
        flip = 1'b1;
        set_req(2, 32'h0000_0000, 32'h1234_5678);
        x.id = 2'd2; x.res = 33'h0_1234_5679;
        sb.push_back(x);
        req_valid_i = 4'b0100;
        wait_grant(ok);
        @(posedge clk_i); #1 req_valid_i = '0;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_id_o !== e.id || rsp_result_o !== e.res || err_o !== 1'b1 || err_cnt_o !== 16'd1) begin
            fails++; $display("FAIL err_flip res=%h err=%b cnt=%0d need %h 1 1", rsp_result_o, err_o, err_cnt_o, e.res);
        end
        @(posedge clk_i); #1;
        flip = 1'b0;
        set_req(2, 32'h0000_0001, 32'h0000_0002);
        push_exp(2, 32'h0000_0001, 32'h0000_0002);
        req_valid_i = 4'b0100;
        wait_grant(ok);
        @(posedge clk_i); #1 req_valid_i = '0;
        wait_hs(ok);
        e = sb.pop_front();
        tests++;
        if (!ok || rsp_result_o !== e.res || err_o !== 1'b0 || err_cnt_o !== 16'd1) begin
            fails++; $display("FAIL err_clean res=%h err=%b cnt=%0d need %h 0 1", rsp_result_o, err_o, err_cnt_o, e.res);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_carry();
        test_fairness();
        test_backpressure();
`ifdef EXACT_CHECK_EN
        test_exact_check();
`endif
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_left %0d entries need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
